// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the request-handler-to-Wishbone bridge.
package mem_bus_pkg;

    // Bridge FSM: waiting for a handler request, or running a Wishbone cycle.
    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } bridge_state_t;

    // Value returned to the handler when a read ends by err_i or timeout.
    localparam logic [31:0] ERR_READ_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter used to bound how long the bridge waits for a slave.
// expired is high while the count sits at LIMIT.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 1022,
    parameter int unsigned WIDTH = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count;

    // Count enabled cycles, holding at LIMIT once reached.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT_V);

endmodule

// File: rtl/mem_bus_bridge.sv
// Accepts one single-cycle read/write request from the handler and runs it as
// a Wishbone classic cycle. mem_busy covers the whole bus cycle; bus_error
// pulses for one cycle when the slave errors or never answers.
//
// Handshake: the handler may present mem_read/mem_write only while mem_busy is
// low; a request is taken at the first edge it is seen in IDLE. On the bus,
// cyc_o/stb_o stay high until the first edge with ack_i, err_i or timeout.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   adr_to_mem,
    input  logic [31:0]   data_to_mem,
    input  logic [3:0]    sel_to_mem,
    output logic [31:0]   data_from_mem,
    output logic          mem_busy,
    output logic          bus_error,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [31:0]   adr_o,
    output logic [31:0]   dat_o,
    output logic [3:0]    sel_o,
    input  logic [31:0]   dat_i,
    input  logic          ack_i,
    input  logic          err_i,
    output bridge_state_t fsm_state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_t state_q;
    bridge_state_t state_d;
    logic          accept;
    logic          done_ok;
    logic          done_err;
    logic          expired;
    logic          we_q;

    // Timeout is measured from the first BUS cycle; the counter is held clear in IDLE.
    bus_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES - 1),
        .WIDTH (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == IDLE),
        .enable  (state_q == BUS),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and completion decode; err_i beats ack_i, ack_i beats timeout.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (err_i) begin
                    done_err = 1'b1;
                    state_d  = IDLE;
                end else if (ack_i) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    done_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, status flags and returned read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_busy      <= 1'b0;
            bus_error     <= 1'b0;
            we_q          <= 1'b0;
            adr_o         <= 32'h0;
            dat_o         <= 32'h0;
            sel_o         <= 4'h0;
            data_from_mem <= 32'h0;
        end else begin
            mem_busy  <= (state_d == BUS);
            bus_error <= done_err;
            if (accept) begin
                adr_o <= adr_to_mem;
                dat_o <= data_to_mem;
                sel_o <= sel_to_mem;
                we_q  <= mem_write;
            end
            if (done_ok && !we_q) begin
                data_from_mem <= dat_i;
            end else if (done_err && !we_q) begin
                data_from_mem <= ERR_READ_DATA;
            end
        end
    end

    // Bus qualifiers follow the state directly so they drop right after reset.
    assign cyc_o     = (state_q == BUS);
    assign stb_o     = (state_q == BUS);
    assign we_o      = (state_q == BUS) && we_q;
    assign fsm_state = state_q;

endmodule
